haze_synth: RTL and testbench
=============================

# haze_synth

Forward atmospheric-scattering stage that synthesises a hazy RGB pixel stream from a clear scene, per-pixel transmission and per-frame atmospheric light, computing I = J·t + A·(1 − t) in 8-bit fixed point. It is the encoding counterpart of the dehazing scene-restoration stage. It feeds that stage's er/eg/eb inputs in self-checking loops and produces synthetic hazy test frames. The block is a 3-stage valid/ready pipeline with frame framing and a per-frame atmospheric-light latch.

## Interface
Parameters:
- IMG_W, 256, pixels per line (≥ 2)
- IMG_H, 256, lines per frame (≥ 1)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input pixel valid
- o_ready  out  1  block can accept input this cycle
- i_sof  in  1  first pixel of frame, qualified by i_valid
- i_jr / i_jg / i_jb  in  8 each  clear-scene pixel J
- i_t  in  8  transmission, Q0.8 (t = i_t/256)
- i_ar / i_ag / i_ab  in  8 each  atmospheric light A; sampled only on an accepted sof beat
- o_valid  out  1  output pixel valid
- i_ready  in  1  downstream can accept
- o_r / o_g / o_b  out  8 each  hazy pixel I
- o_sof  out  1  aligned with output pixel 0 of a frame
- o_eof  out  1  aligned with output pixel IMG_W·IMG_H−1
- o_frame_err  out  1  sticky framing error; cleared only by i_rst

## Operation
- Accept: the input beat is taken when i_valid && o_ready.
- Output: the output beat is transferred when o_valid && i_ready.
- A latch: on an accepted beat with i_sof=1, A is latched from i_ar/ag/ab and used for that pixel and every following pixel until the next accepted sof.
- Pixel counter: range 0..IMG_W·IMG_H−1.
  - Reset to 0 on an accepted sof beat (that beat is pixel 0).
  - Incremented on each other accepted beat.
  - After the last pixel it enters DONE. Beats accepted in DONE without sof set o_frame_err and are still processed, using the held A.
- Counter state machine: IDLE → (accepted sof) → ACTIVE → (accepted last pixel) → DONE → (accepted sof) → ACTIVE.
  - A non-sof beat accepted in IDLE sets o_frame_err. That pixel uses A = 0.
  - A sof accepted in ACTIVE before the count completes sets o_frame_err, then restarts the frame at pixel 0.
- Per channel c, with u = 256 − i_t (9 bits, range 1..256):
  - stage 1: register J, t, u and the A values in use.
  - stage 2: register p = J·t (16 bits) and q = A·u (17 bits).
  - stage 3: register I = (p + q + 128) >> 8.
- Width and saturation: p + q + 128 ≤ 65408, so I always fits in 8 bits. No saturation logic is needed.
- Framing flags: o_sof and o_eof travel down the pipeline with their pixel.

## Timing
- Latency: 3 cycles from an accepted input to o_valid with no back-pressure.
- Throughput: 1 pixel/clock.
- Stall: the pipeline uses a global enable, en = !o_valid || i_ready.
  - o_ready = en. This is combinational from i_ready and o_valid only, never from i_valid.
  - While en = 0, all stage registers hold, so o_r/g/b, o_sof and o_eof stay stable.
- Bubbles: each stage carries its own valid bit, so bubbles propagate and o_valid drops for idle slots.
- Reset values: all outputs 0 (o_valid = 0, o_r/g/b = 0, o_sof = o_eof = 0, o_frame_err = 0) and o_ready = 1 (since o_valid = 0). The FSM goes to IDLE, the counter to 0 and A to 0.
- Reset mid-frame: in-flight pixels are discarded with no output. The next frame must start with sof.
- Simultaneous last-pixel output and new-sof input: both complete in the same cycle. o_eof is on the output side and the counter restarts on the input side.
- A change mid-frame: changes on i_ar/ag/ab without sof are ignored.

## Test plan
- Reset, then a single pixel with sof: J = (200,200,200), t = 128, A = 100 → I = (150,150,150) exactly 3 cycles later, with o_sof = 1 and o_eof = 0.
- Endpoint values:
  - t = 0, J = 0, A = 255 → I = 255.
  - t = 255, J = 200, A = 100 → I = 200.
  - t = 0, J = 17, A = 42 → I = 42.
- Full frame with IMG_W = 4, IMG_H = 2, back-to-back beats → 8 outputs on consecutive cycles, o_sof on output 0, o_eof on output 7, o_frame_err = 0.
- Random i_ready back-pressure over 1000 random pixels against a reference model → every result matches, no loss or duplication, and outputs stay stable while i_ready = 0.
- Framing errors → each sets o_frame_err = 1 and it stays set until i_rst:
  - sof at pixel 3 of an 8-pixel frame: the frame restarts and the new A applies.
  - a non-sof beat after reset.
- i_rst asserted with 3 pixels in flight → o_valid = 0 immediately (asynchronous), and no stale outputs appear after release.

Source files
------------

// File: rtl/haze_synth.sv
// Forward atmospheric-scattering stage: I = J*t + A*(1-t) per channel, 8-bit fixed point,
// 3-stage valid/ready pipeline with frame counting and a per-frame atmospheric-light latch.
module haze_synth #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   output logic       o_ready,
   input  logic       i_sof,
   input  logic [7:0] i_jr,
   input  logic [7:0] i_jg,
   input  logic [7:0] i_jb,
   input  logic [7:0] i_t,
   input  logic [7:0] i_ar,
   input  logic [7:0] i_ag,
   input  logic [7:0] i_ab,
   output logic       o_valid,
   input  logic       i_ready,
   output logic [7:0] o_r,
   output logic [7:0] o_g,
   output logic [7:0] o_b,
   output logic       o_sof,
   output logic       o_eof,
   output logic       o_frame_err
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
   logic                en, acc, err_set, px_eof;
   logic [2:0][7:0]     a_hold, a_use;

   // Stage registers, channel index 2 = red, 1 = green, 0 = blue.
   logic                v1, sof1, eof1;
   logic [2:0][7:0]     j1, a1;
   logic [7:0]          t1;
   logic [8:0]          u1;
   logic                v2, sof2, eof2;
   logic [2:0][15:0]    p2;
   logic [2:0][16:0]    q2;
   logic [2:0][7:0]     i3;

   // p + q + 128 never exceeds 65408, so bits [15:8] hold the whole rounded result.
   function automatic logic [7:0] blend(input logic [15:0] p, input logic [16:0] q);
      return 8'(({1'b0, p} + q + 17'd128) >> 8);
   endfunction

   assign en      = !o_valid || i_ready;
   assign o_ready = en;
   assign acc     = i_valid && en;
   assign cnt_inc = cnt + CW'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      px_eof    = 1'b0;
      a_use     = a_hold;
      if (acc) begin
         if (i_sof) begin
            a_use     = {i_ar, i_ag, i_ab};
            cnt_nxt   = '0;
            state_nxt = ACTIVE;
            err_set   = (state == ACTIVE);
         end else begin
            case (state)
               IDLE: begin
                  err_set = 1'b1;
                  a_use   = '0;
               end
               ACTIVE: begin
                  cnt_nxt = cnt_inc;
                  px_eof  = (cnt_inc == LAST);
                  if (cnt_inc == LAST) state_nxt = DONE;
               end
               DONE:    err_set = 1'b1;
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt         <= '0;
         a_hold      <= '0;
         o_frame_err <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (acc && i_sof) a_hold <= {i_ar, i_ag, i_ab};
         if (err_set) o_frame_err <= 1'b1;
      end
   end

   // Valid and framing bits move together under the global enable so bubbles propagate.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1 <= 1'b0; sof1 <= 1'b0; eof1 <= 1'b0;
         v2 <= 1'b0; sof2 <= 1'b0; eof2 <= 1'b0;
         o_valid <= 1'b0; o_sof <= 1'b0; o_eof <= 1'b0;
         i3 <= '0;
      end else if (en) begin
         v1      <= acc;
         sof1    <= acc && i_sof;
         eof1    <= acc && px_eof;
         v2      <= v1;
         sof2    <= sof1;
         eof2    <= eof1;
         o_valid <= v2;
         o_sof   <= sof2;
         o_eof   <= eof2;
         for (int c = 0; c < 3; c++) i3[c] <= blend(p2[c], q2[c]);
      end
   end

   // NOTE: internal datapath registers carry no reset; their contents are only observed
   // through the valid bits, which are reset, so clearing them would buy nothing.
   always_ff @(posedge i_clk) begin
      if (en) begin
         j1 <= {i_jr, i_jg, i_jb};
         t1 <= i_t;
         u1 <= 9'd256 - {1'b0, i_t};
         a1 <= a_use;
         for (int c = 0; c < 3; c++) begin
            p2[c] <= 16'(j1[c]) * 16'(t1);
            q2[c] <= 17'(a1[c]) * 17'(u1);
         end
      end
   end

   assign o_r = i3[2];
   assign o_g = i3[1];
   assign o_b = i3[0];

endmodule

// File: tb/tb_haze_synth.sv
// Self-checking bench for haze_synth: directed endpoint/framing/reset scenarios plus
// randomized back-pressure traffic scored against an arithmetic reference model.
module tb_haze_synth;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int NPIX = W * H;

   logic       i_clk = 1'b0;
   logic       i_rst, i_valid, o_ready, i_sof;
   logic [7:0] i_jr, i_jg, i_jb, i_t, i_ar, i_ag, i_ab;
   logic       o_valid, i_ready;
   logic [7:0] o_r, o_g, o_b;
   logic       o_sof, o_eof, o_frame_err;

   haze_synth #(.IMG_W(W), .IMG_H(H)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_sof(i_sof),
      .i_jr(i_jr), .i_jg(i_jg), .i_jb(i_jb), .i_t(i_t),
      .i_ar(i_ar), .i_ag(i_ag), .i_ab(i_ab),
      .o_valid(o_valid), .i_ready(i_ready), .o_r(o_r), .o_g(o_g), .o_b(o_b),
      .o_sof(o_sof), .o_eof(o_eof), .o_frame_err(o_frame_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int r, g, b;
      bit sof, eof;
   } pix_t;

   pix_t q[$];
   int   errors = 0, checks = 0, n_sent = 0, n_recv = 0;
   bit   rand_ready = 1'b0;

   // Reference model: frame position as a plain integer, -1 before any sof.
   int   m_idx = -1;
   bit   m_err = 1'b0;
   int   m_a[3] = '{0, 0, 0};

   function automatic int hz(int j, int t, int a);
      return (j * t + a * (256 - t) + 128) / 256;
   endfunction

   task automatic model_reset();
      m_idx = -1;
      m_err = 1'b0;
      m_a   = '{0, 0, 0};
      q.delete();
   endtask

   task automatic model_accept();
      int ar, ag, ab;
      bit eof;
      eof = 1'b0;
      if (i_sof) begin
         if (m_idx >= 0 && m_idx < NPIX - 1) m_err = 1'b1;
         m_idx = 0;
         m_a[0] = int'(i_ar); m_a[1] = int'(i_ag); m_a[2] = int'(i_ab);
      end else if (m_idx < 0) begin
         m_err = 1'b1;
      end else if (m_idx == NPIX - 1) begin
         m_err = 1'b1;
      end else begin
         m_idx++;
         eof = (m_idx == NPIX - 1);
      end
      ar = (m_idx < 0) ? 0 : m_a[0];
      ag = (m_idx < 0) ? 0 : m_a[1];
      ab = (m_idx < 0) ? 0 : m_a[2];
      q.push_back('{hz(int'(i_jr), int'(i_t), ar), hz(int'(i_jg), int'(i_t), ag),
                    hz(int'(i_jb), int'(i_t), ab), i_sof, eof});
      n_sent++;
   endtask

   // Called just after a rising edge; returns just after the edge that took the beat.
   task automatic send(input logic sof, input logic [7:0] jr, jg, jb, t, ar, ag, ab);
      bit taken;
      taken = 1'b0;
      i_valid = 1'b1; i_sof = sof;
      i_jr = jr; i_jg = jg; i_jb = jb; i_t = t;
      i_ar = ar; i_ag = ag; i_ab = ab;
      for (int k = 0; k < 200 && !taken; k++) begin
         @(negedge i_clk);
         if (o_ready) begin
            model_accept();
            taken = 1'b1;
         end
         @(posedge i_clk); #1;
      end
      if (!taken) begin
         checks++; errors++;
         $display("FAIL accept_timeout: o_ready=%0b after 200 cycles, required 1", o_ready);
      end
      i_valid = 1'b0; i_sof = 1'b0;
   endtask

   task automatic rsend(input logic sof);
      send(sof, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_valid = 1'b0; i_sof = 1'b0;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 500) begin
         @(negedge i_clk);
         k++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d outputs still pending, required 0", q.size());
      end
      @(posedge i_clk); #1;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge i_clk);
         ok = o_valid;
      end
   endtask

   // Output scoreboard plus stall-stability monitor.
   initial begin : monitor
      bit       held;
      logic [25:0] held_v;
      pix_t     e;
      held = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               checks++;
               if ({o_valid, o_r, o_g, o_b, o_sof, o_eof} !== {1'b1, held_v}) begin
                  errors++;
                  $display("FAIL stall_stable: got v=%0b %h, held %h", o_valid,
                           {o_r, o_g, o_b, o_sof, o_eof}, held_v);
               end
            end
            held = o_valid && !i_ready;
            held_v = {o_r, o_g, o_b, o_sof, o_eof};
            if (o_valid && i_ready) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output: got rgb=%0d,%0d,%0d with nothing pending",
                           o_r, o_g, o_b);
               end else begin
                  e = q.pop_front();
                  n_recv++;
                  if ({o_r, o_g, o_b, o_sof, o_eof} !==
                      {8'(e.r), 8'(e.g), 8'(e.b), e.sof, e.eof}) begin
                     errors++;
                     $display("FAIL pixel: got rgb=%0d,%0d,%0d sof=%0b eof=%0b, expected rgb=%0d,%0d,%0d sof=%0b eof=%0b",
                              o_r, o_g, o_b, o_sof, o_eof, e.r, e.g, e.b, e.sof, e.eof);
                  end
               end
            end
         end
      end
   end

   initial begin : ready_drv
      i_ready = 1'b1;
      forever begin
         @(posedge i_clk); #1;
         i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0;
      i_jr = '0; i_jg = '0; i_jb = '0; i_t = '0; i_ar = '0; i_ag = '0; i_ab = '0;
      #1;
      checks++;
      if ({o_valid, o_ready, o_r, o_g, o_b, o_sof, o_eof, o_frame_err} !== {2'b01, 24'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_state: got v=%0b rdy=%0b rgb=%h sof=%0b eof=%0b err=%0b, expected rdy=1 rest 0",
                  o_valid, o_ready, {o_r, o_g, o_b}, o_sof, o_eof, o_frame_err);
      end
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
   endtask

   task automatic test_single_pixel();
      int lat;
      do_reset();
      send(1'b1, 8'd200, 8'd200, 8'd200, 8'd128, 8'd100, 8'd100, 8'd100);
      lat = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         if (o_valid) break;
         lat++;
      end
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required 3", lat);
      end
      checks++;
      if ({o_r, o_g, o_b, o_sof, o_eof} !== {8'd150, 8'd150, 8'd150, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_pixel: got rgb=%0d,%0d,%0d sof=%0b eof=%0b, required 150,150,150 sof=1 eof=0",
                  o_r, o_g, o_b, o_sof, o_eof);
      end
      drain();
   endtask

   task automatic endpoint(input logic [7:0] j, t, a, exp_i);
      bit ok;
      do_reset();
      send(1'b1, j, j, j, t, a, a, a);
      wait_valid(ok);
      checks++;
      if (!ok || {o_r, o_g, o_b} !== {exp_i, exp_i, exp_i}) begin
         errors++;
         $display("FAIL endpoint_j%0d_t%0d_a%0d: got valid=%0b rgb=%0d,%0d,%0d, required %0d",
                  j, t, a, ok, o_r, o_g, o_b, exp_i);
      end
      drain();
   endtask

   task automatic test_endpoints();
      endpoint(8'd0, 8'd0, 8'd255, 8'd255);
      endpoint(8'd200, 8'd255, 8'd100, 8'd200);
      endpoint(8'd17, 8'd0, 8'd42, 8'd42);
   endtask

   task automatic test_back_to_back();
      do_reset();
      fork
         begin
            for (int n = 0; n < 2 * NPIX; n++) rsend(n % NPIX == 0);
         end
         begin
            bit ok;
            wait_valid(ok);
            for (int k = 0; k < 2 * NPIX; k++) begin
               checks++;
               if ({o_valid, o_sof, o_eof} !== {1'b1, k % NPIX == 0, k % NPIX == NPIX - 1}) begin
                  errors++;
                  $display("FAIL frame_beat%0d: got v=%0b sof=%0b eof=%0b, required v=1 sof=%0b eof=%0b",
                           k, o_valid, o_sof, o_eof, k % NPIX == 0, k % NPIX == NPIX - 1);
               end
               if (k != 2 * NPIX - 1) @(negedge i_clk);
            end
         end
      join
      drain();
      checks++;
      if (o_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL frame_err_clean: got %0b, required 0", o_frame_err);
      end
   endtask

   task automatic test_backpressure();
      int sent0, recv0;
      do_reset();
      sent0 = n_sent; recv0 = n_recv;
      rand_ready = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         rsend(n % NPIX == 0);
      end
      drain();
      rand_ready = 1'b0;
      checks++;
      if (n_recv - recv0 != 1000 || n_sent - sent0 != 1000) begin
         errors++;
         $display("FAIL bp_count: got %0d outputs for %0d inputs, required 1000", n_recv - recv0, n_sent - sent0);
      end
      checks++;
      if (o_frame_err !== m_err) begin
         errors++;
         $display("FAIL bp_frame_err: got %0b, required %0b", o_frame_err, m_err);
      end
   endtask

   task automatic test_frame_errors();
      do_reset();
      send(1'b1, 8'd10, 8'd20, 8'd30, 8'd64, 8'd10, 8'd10, 8'd10);
      for (int n = 1; n < 3; n++) rsend(1'b0);
      send(1'b1, 8'd10, 8'd20, 8'd30, 8'd64, 8'd200, 8'd150, 8'd250);
      for (int n = 1; n < NPIX; n++) rsend(1'b0);
      drain();
      checks++;
      if (o_frame_err !== 1'b1) begin
         errors++;
         $display("FAIL early_sof_err: got %0b, required 1", o_frame_err);
      end
      for (int n = 0; n < NPIX; n++) rsend(n == 0);
      drain();
      checks++;
      if (o_frame_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %0b, required 1", o_frame_err);
      end
      do_reset();
      checks++;
      if (o_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got %0b, required 0", o_frame_err);
      end
      send(1'b0, 8'd100, 8'd50, 8'd25, 8'd128, 8'd77, 8'd77, 8'd77);
      drain();
      checks++;
      if (o_frame_err !== 1'b1) begin
         errors++;
         $display("FAIL idle_beat_err: got %0b, required 1", o_frame_err);
      end
   endtask

   task automatic test_reset_in_flight();
      int stale;
      do_reset();
      for (int n = 0; n < 3; n++) rsend(n == 0);
      #2 i_rst = 1'b1;
      #1;
      checks++;
      if ({o_valid, o_r, o_g, o_b, o_sof, o_eof} !== 27'd0) begin
         errors++;
         $display("FAIL async_reset: got v=%0b rgb=%h, required all 0", o_valid, {o_r, o_g, o_b});
      end
      model_reset();
      @(posedge i_clk); #1 i_rst = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge i_clk);
         if (o_valid) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL stale_outputs: got %0d valid cycles after reset, required 0", stale);
      end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_endpoints();
      test_back_to_back();
      test_backpressure();
      test_frame_errors();
      test_reset_in_flight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
